// File: rtl/valu_arbiter.sv
// Round-robin front end for the shared 64-bit vector ALU.
// Takes one op at a time from two requesters, sequences the ALU start/result
// handshake, guards against a hung ALU with a watchdog and routes the tagged
// result back to the issuing requester.
`timescale 1ns/1ps
module valu_arbiter #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [1:0]       req0_sew,
   input  logic [63:0]      req0_vs1,
   input  logic [63:0]      req0_vs2,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [1:0]       req1_sew,
   input  logic [63:0]      req1_vs1,
   input  logic [63:0]      req1_vs2,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [63:0]      rsp0_data,
   output logic             rsp0_err,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [63:0]      rsp1_data,
   output logic             rsp1_err,
   output logic [1:0]       alu_op,
   output logic [1:0]       alu_sew,
   output logic [63:0]      alu_vs1,
   output logic [63:0]      alu_vs2,
   output logic             alu_valid_in,
   input  logic             alu_valid_out,
   input  logic [63:0]      alu_result,
   output logic             busy,
   output logic [CNT_W-1:0] cnt_ops,
   output logic [CNT_W-1:0] cnt_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t      state, state_nx;
   logic        last_grant, grant, take, gid_q, rsp_done, timeout;
   logic [1:0]  sel_op, sel_sew, op_q, sew_q;
   logic [63:0] sel_vs1, sel_vs2, vs1_q, vs2_q, data_q;
   logic        err_q;
   logic [7:0]  wd_q;

   // Grant selection: a lone requester wins, a tie goes to the one not served last
   always_comb begin
      grant = ~last_grant;
      if (req0_valid && !req1_valid) begin
         grant = 1'b0;
      end else if (req1_valid && !req0_valid) begin
         grant = 1'b1;
      end
      sel_op  = grant ? req1_op  : req0_op;
      sel_sew = grant ? req1_sew : req0_sew;
      sel_vs1 = grant ? req1_vs1 : req0_vs1;
      sel_vs2 = grant ? req1_vs2 : req0_vs2;
   end

   assign take       = (state == IDLE) && (grant ? req1_valid : req0_valid);
   assign req0_ready = (state == IDLE) && req0_valid && !grant;
   assign req1_ready = (state == IDLE) && req1_valid && grant;
   assign rsp_done   = (state == RESP) && (gid_q ? rsp1_ready : rsp0_ready);
   assign timeout    = (wd_q == 8'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (take) state_nx = (sel_sew == 2'b11) ? RESP : ISSUE;
         ISSUE:   state_nx = WAIT;
         WAIT:    if (alu_valid_out || timeout) state_nx = RESP;
         RESP:    if (rsp_done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand capture, watchdog, result capture and statistics
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         gid_q      <= 1'b0;
         op_q       <= '0;
         sew_q      <= '0;
         vs1_q      <= '0;
         vs2_q      <= '0;
         data_q     <= '0;
         err_q      <= 1'b0;
         wd_q       <= '0;
         cnt_ops    <= '0;
         cnt_err    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  op_q       <= sel_op;
                  sew_q      <= sel_sew;
                  vs1_q      <= sel_vs1;
                  vs2_q      <= sel_vs2;
                  gid_q      <= grant;
                  last_grant <= grant;
                  data_q     <= '0;
                  err_q      <= (sel_sew == 2'b11);
               end
            end
            ISSUE: wd_q <= '0;
            WAIT: begin
               if (alu_valid_out) begin
                  data_q <= alu_result;
                  err_q  <= 1'b0;
               end else if (timeout) begin
                  data_q <= '0;
                  err_q  <= 1'b1;
               end else begin
                  wd_q <= wd_q + 8'd1;
               end
            end
            RESP: begin
               if (rsp_done) begin
                  if (err_q) cnt_err <= cnt_err + 1'b1;
                  else       cnt_ops <= cnt_ops + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Operand registers only change on accept, so the ALU sees stable inputs
   assign alu_op       = op_q;
   assign alu_sew      = sew_q;
   assign alu_vs1      = vs1_q;
   assign alu_vs2      = vs2_q;
   assign alu_valid_in = (state == ISSUE);
   assign busy         = (state != IDLE);
   assign rsp0_valid   = (state == RESP) && !gid_q;
   assign rsp1_valid   = (state == RESP) && gid_q;
   assign rsp0_data    = data_q;
   assign rsp1_data    = data_q;
   assign rsp0_err     = err_q;
   assign rsp1_err     = err_q;

endmodule
